wait_state_data_memory: RTL and testbench

- Parametrised successor to the single-cycle external data memory, attached to the shared 20-bit-address system bus.
- Generic data width with byte-lane write enables.
- Configurable wait states, with a `ready` handshake so the CPU bus can stall on slower memory.
- Read data is registered (synchronous) rather than asynchronous; read/write conflicts are flagged on an error line.

---
 rtl/wait_state_data_memory.sv | 173 +++++++++++++++++
 tb/tb_wait_state_data_memory.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wait_state_data_memory.sv
// Word-addressed data memory on the shared system bus with byte-lane writes,
// programmable wait states, a tri-stated ready strobe and a registered read port.
module wait_state_data_memory #(
    parameter int    START_ADDRESS = 0,
    parameter int    SIZE          = 1024,
    parameter int    DATA_WIDTH    = 16,
    parameter int    ADDR_WIDTH    = 20,
    parameter int    WAIT_STATES   = 1,
    parameter string INIT_FILE     = ""
) (
    input  logic                    clk,
    input  logic                    rst_n,
    inout  logic [DATA_WIDTH-1:0]   bus_data,
    input  logic [ADDR_WIDTH-1:0]   bus_addr,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    output logic                    ready,
    output logic                    error
);

    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   ADDR_LO = (ADDR_WIDTH + 1)'(START_ADDRESS);
    localparam logic [ADDR_WIDTH-1:0] SPAN    = ADDR_WIDTH'(SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            wcnt_q, wcnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  op_write_q, op_write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]       be_q, be_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  error_q, error_d;

    logic [DATA_WIDTH-1:0] mem [SIZE];

    logic [ADDR_WIDTH:0]   addr_diff;
    logic                  selected;
    logic [IDX_W-1:0]      bus_idx;
    logic [IDX_W-1:0]      txn_idx;
    logic                  txn_write;
    logic [DATA_WIDTH-1:0] txn_wdata;
    logic [BE_W-1:0]       txn_be;
    logic                  abort;
    logic                  enter_ack;
    logic                  mem_we;
    logic                  ready_drv;
    logic                  ready_en;
    logic                  data_en;

    // The borrow bit of a one-bit-wider subtraction gives the lower bound without
    // a comparison that would be constant when the window starts at zero.
    assign addr_diff = {1'b0, bus_addr} - ADDR_LO;
    assign selected  = !addr_diff[ADDR_WIDTH] && (addr_diff[ADDR_WIDTH-1:0] <= SPAN);
    assign bus_idx   = addr_diff[IDX_W-1:0];

    // In IDLE the transaction fields come straight off the bus so that a
    // zero-wait-state access can commit on its accepting edge.
    always_comb begin
        txn_idx   = idx_q;
        txn_write = op_write_q;
        txn_wdata = wdata_q;
        txn_be    = be_q;
        if (state_q == S_IDLE) begin
            txn_idx   = bus_idx;
            txn_write = write;
            txn_wdata = bus_data;
            txn_be    = byte_en;
        end
    end

    assign abort = op_write_q ? (!write || read || !selected)
                              : (!read || write || !selected);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wcnt_q     <= 4'd0;
            idx_q      <= '0;
            op_write_q <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
            rdata_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            idx_q      <= idx_d;
            op_write_q <= op_write_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            rdata_q    <= rdata_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        idx_d      = idx_q;
        op_write_d = op_write_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        error_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                error_d = selected && read && write;
                if (selected && (read ^ write)) begin
                    idx_d      = bus_idx;
                    op_write_d = write;
                    wdata_d    = bus_data;
                    be_d       = byte_en;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        wcnt_d  = 4'(WAIT_STATES - 1);
                    end else begin
                        state_d = S_ACK;
                    end
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                    wcnt_d  = 4'd0;
                end else if (wcnt_q == 4'd0) begin
                    state_d = S_ACK;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Memory and read register are updated only on the edge that enters ACK.
    always_comb begin
        enter_ack = (state_d == S_ACK) && (state_q != S_ACK);
        mem_we    = enter_ack && txn_write && rst_n;
        rdata_d   = rdata_q;
        if (enter_ack && !txn_write) begin
            rdata_d = mem[txn_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (txn_be[i]) begin
                    mem[txn_idx][8*i +: 8] <= txn_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        ready_drv = (state_q == S_ACK);
        ready_en  = (state_q == S_ACK) || selected;
        data_en   = (state_q == S_ACK) && !op_write_q && read && selected;
    end

    assign ready    = ready_en ? ready_drv : 1'bz;
    assign bus_data = data_en ? rdata_q : {DATA_WIDTH{1'bz}};
    assign error    = error_q;

endmodule

// File: tb/tb_wait_state_data_memory.sv
// Bench for wait_state_data_memory: two instances (two and zero wait states)
// driven by random and directed transfers, checked against an array model.
module tb_wait_state_data_memory;

    localparam int DW    = 16;
    localparam int AW    = 20;
    localparam int START = 32'h00100;
    localparam int SIZE  = 256;
    localparam int WS0   = 2;
    localparam int WS1   = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] addr0, addr1;
    logic          rd0, wr0, rd1, wr1;
    logic [1:0]    be0, be1;
    logic [DW-1:0] drv0, drv1;
    logic          den0, den1;
    wire  [DW-1:0] bus0, bus1;
    wire           rdy0, rdy1, err0, err1;

    assign bus0 = den0 ? drv0 : {DW{1'bz}};
    assign bus1 = den1 ? drv1 : {DW{1'bz}};

    wait_state_data_memory #(
        .START_ADDRESS(START), .SIZE(SIZE), .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW), .WAIT_STATES(WS0), .INIT_FILE("")
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .bus_data(bus0), .bus_addr(addr0),
        .read(rd0), .write(wr0), .byte_en(be0), .ready(rdy0), .error(err0)
    );

    wait_state_data_memory #(
        .START_ADDRESS(START), .SIZE(SIZE), .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW), .WAIT_STATES(WS1), .INIT_FILE("")
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .bus_data(bus1), .bus_addr(addr1),
        .read(rd1), .write(wr1), .byte_en(be1), .ready(rdy1), .error(err1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int            cyc;
        bit            chk;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q0[$];
    exp_t          exp_q1[$];
    int            exp_err_q[$];
    logic [DW-1:0] model0 [SIZE];
    logic [DW-1:0] model1 [SIZE];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_neg();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [1:0] be);
        logic [DW-1:0] mask;
        mask = {{8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (nw & mask);
    endfunction

    function automatic logic get_rdy(input int w);
        return (w == 0) ? rdy0 : rdy1;
    endfunction

    task automatic set_bus(input int w, input bit rd, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [1:0] be, input bit den);
        if (w == 0) begin
            rd0 = rd; wr0 = wr; addr0 = a; drv0 = d; be0 = be; den0 = den;
        end else begin
            rd1 = rd; wr1 = wr; addr1 = a; drv1 = d; be1 = be; den1 = den;
        end
    endtask

    // One complete bus transfer; in-window accesses push their expected ready.
    task automatic xfer(input int w, input bit is_wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [1:0] be);
        exp_t e;
        int   idx;
        int   ws;
        bit   got;
        ws  = (w == 0) ? WS0 : WS1;
        idx = int'(addr) - START;
        set_bus(w, !is_wr, is_wr, addr, data, be, is_wr);
        if (idx < 0 || idx >= SIZE) begin
            repeat (4) wait_neg();
            set_bus(w, 1'b0, 1'b0, addr, '0, 2'b00, 1'b0);
            wait_neg();
            return;
        end
        e.cyc = cyc + ws + 1;
        e.chk = !is_wr;
        e.data = '0;
        if (w == 0) begin
            if (is_wr) model0[idx] = merge(model0[idx], data, be);
            else e.data = model0[idx];
            exp_q0.push_back(e);
        end else begin
            if (is_wr) model1[idx] = merge(model1[idx], data, be);
            else e.data = model1[idx];
            exp_q1.push_back(e);
        end
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            wait_neg();
            got = (get_rdy(w) === 1'b1);
        end
        if (!got) check("ready_timeout", 32'd0, 32'd1);
        set_bus(w, 1'b0, 1'b0, addr, '0, 2'b00, 1'b0);
        wait_neg();
    endtask

    task automatic mon_ready(input int w, input logic [DW-1:0] d);
        exp_t e;
        int   depth;
        depth = (w == 0) ? exp_q0.size() : exp_q1.size();
        if (depth == 0) begin
            check((w == 0) ? "unexpected_ready0" : "unexpected_ready1", 32'd1, 32'd0);
        end else begin
            e = (w == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check((w == 0) ? "ready_cycle0" : "ready_cycle1", cyc, e.cyc);
            if (e.chk) check((w == 0) ? "read_data0" : "read_data1", d, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rdy0 === 1'b1) mon_ready(0, bus0);
            if (rdy1 === 1'b1) mon_ready(1, bus1);
            if (err0 === 1'b1) begin
                if (exp_err_q.size() == 0) check("unexpected_error0", 32'd1, 32'd0);
                else check("error_cycle", cyc, exp_err_q.pop_front());
            end
            if (err1 === 1'b1) check("unexpected_error1", 32'd1, 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        int            n0;
        set_bus(0, 1'b0, 1'b0, AW'(START), '0, 2'b00, 1'b0);
        set_bus(1, 1'b0, 1'b0, AW'(START), '0, 2'b00, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", rdy0, 32'd0);
        check("rst_error", err0, 32'd0);
        check("rst_rdata", dut0.rdata_q, 32'd0);
        rst_n = 1'b1;
        wait_neg();

        for (int i = 0; i < SIZE; i++) xfer(0, 1'b1, AW'(START + i), DW'($urandom_range(16'hFFFF, 1)), 2'b11);
        for (int i = 0; i < 16; i++)   xfer(1, 1'b1, AW'(START + i), DW'($urandom_range(16'hFFFF, 1)), 2'b11);

        xfer(0, 1'b1, 20'h00105, 16'hBEEF, 2'b11);
        xfer(0, 1'b0, 20'h00105, '0, 2'b00);
        xfer(0, 1'b1, 20'h00105, 16'h1234, 2'b01);
        xfer(0, 1'b0, 20'h00105, '0, 2'b00);
        xfer(0, 1'b0, 20'h00104, '0, 2'b00);
        xfer(0, 1'b0, 20'h00106, '0, 2'b00);

        set_bus(0, 1'b1, 1'b0, 20'h000FF, '0, 2'b11, 1'b0);
        repeat (10) begin wait_neg(); check("oob_low_ready", rdy0 === 1'b1, 32'd0); end
        set_bus(0, 1'b1, 1'b0, 20'h00200, '0, 2'b11, 1'b0);
        repeat (10) begin wait_neg(); check("oob_high_ready", rdy0 === 1'b1, 32'd0); end
        set_bus(0, 1'b0, 1'b0, 20'h00200, '0, 2'b00, 1'b0);
        wait_neg();
        xfer(0, 1'b0, 20'h00105, '0, 2'b00);

        set_bus(0, 1'b0, 1'b1, 20'h00110, 16'hAAAA, 2'b11, 1'b1);
        wait_neg();
        set_bus(0, 1'b0, 1'b0, 20'h00110, '0, 2'b00, 1'b0);
        repeat (6) wait_neg();
        xfer(0, 1'b0, 20'h00110, '0, 2'b00);

        set_bus(0, 1'b1, 1'b1, 20'h00120, '0, 2'b11, 1'b0);
        exp_err_q.push_back(cyc + 1);
        exp_err_q.push_back(cyc + 2);
        repeat (2) wait_neg();
        set_bus(0, 1'b0, 1'b0, 20'h00120, '0, 2'b00, 1'b0);
        repeat (4) wait_neg();
        xfer(0, 1'b0, 20'h00120, '0, 2'b00);

        xfer(0, 1'b0, 20'h00105, '0, 2'b00);
        set_bus(0, 1'b0, 1'b1, 20'h00130, 16'h5555, 2'b11, 1'b1);
        wait_neg();
        rst_n = 1'b0;
        #1;
        check("midwait_rst_ready", rdy0, 32'd0);
        check("midwait_rst_error", err0, 32'd0);
        check("midwait_rst_rdata", dut0.rdata_q, 32'd0);
        set_bus(0, 1'b0, 1'b0, 20'h00130, '0, 2'b00, 1'b0);
        wait_neg();
        rst_n = 1'b1;
        repeat (2) wait_neg();
        xfer(0, 1'b0, 20'h00130, '0, 2'b00);

        for (int i = 0; i < 200; i++) begin
            a = AW'($urandom_range(START + SIZE + 15, START - 16));
            xfer(0, 1'($urandom_range(1, 0)), a, DW'($urandom), 2'($urandom_range(3, 0)));
        end
        for (int i = 0; i < 40; i++) begin
            a = AW'($urandom_range(START + 15, START));
            xfer(1, 1'($urandom_range(1, 0)), a, DW'($urandom), 2'($urandom_range(3, 0)));
        end

        repeat (5) wait_neg();
        n0 = exp_q0.size();
        check("pending_ready0", n0, 32'd0);
        check("pending_ready1", exp_q1.size(), 32'd0);
        check("pending_error", exp_err_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
